inst_cache_loader: RTL and testbench

Program loader that streams 32-bit instruction words into the 4096-word instruction cache through its debug write port. Optionally reads the words back through the debug read port to verify them. Sits between the host/debug link (valid/ready word stream) and the cache's `write_en`/`debug_addr`/`debug_input`/`debug_data` pins. It is the writer counterpart to the cache's fetch-side reader.

---
 rtl/inst_loader_pkg.sv | 28 ++
 rtl/inst_loader_vbuf.sv | 26 ++
 rtl/inst_cache_loader.sv | 173 +++++++++++++++++
 tb/tb_inst_cache_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-cache program loader: FSM states,
// cache geometry and the load-range check.
package inst_loader_pkg;

    localparam int unsigned DEPTH_WORDS = 4096;
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W       = IDX_W + 1;

    localparam logic [17:0]    CACHE_ADDR_HI_ZERO = 18'h0;
    localparam logic [CNT_W:0] DEPTH_END          = DEPTH_WORDS[CNT_W:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FLUSH,
        ST_VERIFY,
        ST_DONE
    } state_t;

    // True when the requested image would run past the last cache word.
    function automatic logic range_bad(input logic [IDX_W-1:0] base,
                                       input logic [CNT_W-1:0] count);
        logic [CNT_W:0] w_end;
        w_end = {2'b00, base} + {1'b0, count};
        return (w_end > DEPTH_END);
    endfunction

endpackage

// File: rtl/inst_loader_vbuf.sv
// Verify copy buffer: stores each accepted word by load offset and returns
// the word at the requested offset one cycle later.
module inst_loader_vbuf
    import inst_loader_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [31:0]      i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_data
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_idx];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/inst_cache_loader.sv
// Streams instruction words into the cache debug write port; define
// INST_LOADER_VERIFY_EN to add a readback compare pass after the writes.
module inst_cache_loader
    import inst_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [11:0] i_base_addr,
    input  logic [12:0] i_word_count,
    input  logic        i_in_valid,
    input  logic [31:0] i_in_data,
    output logic        o_in_ready,
    output logic        o_cache_write_en,
    output logic [29:0] o_cache_addr,
    output logic [31:0] o_cache_wdata,
    input  logic [31:0] i_cache_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [11:0] o_err_addr,
    output logic [12:0] o_words_written
);

    state_t           r_state, w_next_state;
    logic [IDX_W-1:0] r_base, r_addr_idx, r_err_addr;
    logic [CNT_W-1:0] r_count, r_acc, r_words;
    logic [31:0]      r_wdata;
    logic             r_we, r_busy, r_done, r_error;
    logic             w_in_ready, w_hs, w_last_hs, w_range_bad;

`ifdef INST_LOADER_VERIFY_EN
    logic [CNT_W-1:0] r_vcnt;
    logic [31:0]      w_exp;
    logic             w_mismatch, w_verify_end;

    inst_loader_vbuf u_vbuf (
        .i_clk     (i_clk),
        .i_wr_en   (w_hs),
        .i_wr_idx  (r_acc[IDX_W-1:0]),
        .i_wr_data (i_in_data),
        .i_rd_idx  (r_vcnt[IDX_W-1:0]),
        .o_rd_data (w_exp)
    );

    // r_vcnt == j compares the read issued at offset j-1; j == count is the final compare.
    assign w_verify_end = (r_vcnt == r_count);
    assign w_mismatch   = (r_vcnt != '0) && (i_cache_rdata != w_exp);
`else
    logic [31:0] w_unused_rdata;
    assign w_unused_rdata = i_cache_rdata;
`endif

    assign w_range_bad = range_bad(i_base_addr, i_word_count);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (w_range_bad || (i_word_count == '0)) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (w_last_hs) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
`ifdef INST_LOADER_VERIFY_EN
                w_next_state = ST_VERIFY;
`else
                w_next_state = ST_DONE;
`endif
            end
            ST_VERIFY: begin
`ifdef INST_LOADER_VERIFY_EN
                if (w_verify_end) begin
                    w_next_state = ST_DONE;
                end
`else
                w_next_state = ST_DONE;
`endif
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == ST_WRITE) && (r_acc < r_count);
        w_hs       = w_in_ready && i_in_valid;
        w_last_hs  = w_hs && ((r_acc + CNT_W'(1)) == r_count);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base     <= '0;
            r_count    <= '0;
            r_acc      <= '0;
            r_words    <= '0;
            r_addr_idx <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_addr <= '0;
`ifdef INST_LOADER_VERIFY_EN
            r_vcnt     <= '0;
`endif
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= (w_next_state == ST_DONE);
            r_we   <= w_hs;
            if ((r_state == ST_IDLE) && i_start) begin
                if (w_range_bad) begin
                    r_error    <= 1'b1;
                    r_err_addr <= i_base_addr;
                end else begin
                    r_base  <= i_base_addr;
                    r_count <= i_word_count;
                    r_acc   <= '0;
                    r_words <= '0;
                    r_error <= 1'b0;
                end
            end
            if (w_hs) begin
                r_addr_idx <= r_base + r_acc[IDX_W-1:0];
                r_wdata    <= i_in_data;
                r_acc      <= r_acc + CNT_W'(1);
                r_words    <= r_words + CNT_W'(1);
            end
`ifdef INST_LOADER_VERIFY_EN
            if (r_state == ST_FLUSH) begin
                r_addr_idx <= r_base;
                r_vcnt     <= '0;
            end
            if (r_state == ST_VERIFY) begin
                r_vcnt     <= r_vcnt + CNT_W'(1);
                r_addr_idx <= r_base + r_vcnt[IDX_W-1:0] + IDX_W'(1);
                if (w_mismatch && !r_error) begin
                    r_error    <= 1'b1;
                    r_err_addr <= r_base + r_vcnt[IDX_W-1:0] - IDX_W'(1);
                end
            end
`endif
        end
    end

    assign o_in_ready       = w_in_ready;
    assign o_cache_write_en = r_we;
    assign o_cache_addr     = {CACHE_ADDR_HI_ZERO, r_addr_idx};
    assign o_cache_wdata    = r_wdata;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_error          = r_error;
    assign o_err_addr       = r_err_addr;
    assign o_words_written  = r_words;

endmodule

// File: tb/tb_inst_cache_loader.sv
// Randomized self-checking bench for inst_cache_loader with a behavioural
// cache model and load-level reference model; honours INST_LOADER_VERIFY_EN.
module tb_inst_cache_loader;

`ifdef INST_LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready;
    logic [11:0] base_addr, err_addr;
    logic [12:0] word_count, words_written;
    logic [31:0] in_data, cache_wdata, cache_rdata;
    logic [29:0] cache_addr;
    logic        cache_write_en, busy, done, error;

    always #5 clk = ~clk;

    inst_cache_loader dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_base_addr      (base_addr),
        .i_word_count     (word_count),
        .i_in_valid       (in_valid),
        .i_in_data        (in_data),
        .o_in_ready       (in_ready),
        .o_cache_write_en (cache_write_en),
        .o_cache_addr     (cache_addr),
        .o_cache_wdata    (cache_wdata),
        .i_cache_rdata    (cache_rdata),
        .o_busy           (busy),
        .o_done           (done),
        .o_error          (error),
        .o_err_addr       (err_addr),
        .o_words_written  (words_written)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem   [4096];
    logic [31:0] words [4096];
    int          ld_base, hs_k, wr_seen;
    bit          pend_we;
    logic [11:0] pend_addr;
    logic [31:0] pend_data;
    bit          corrupt_on;
    logic [11:0] corrupt_addr;
    int          model_written, model_err_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cache model: write port plus registered debug read, with optional bit flip on readback.
    always @(posedge clk) begin
        if (cache_write_en) mem[cache_addr[11:0]] <= cache_wdata;
        cache_rdata <= mem[cache_addr[11:0]] ^
                       ((corrupt_on && cache_addr[11:0] == corrupt_addr) ? 32'h0000_0100 : 32'h0);
    end

    // Every handshake must produce exactly one write pulse in the following cycle.
    always @(posedge clk) begin
        if (rst) begin
            pend_we = 1'b0;
        end else begin
            pend_we = in_ready && in_valid;
            if (pend_we) begin
                pend_addr = 12'(ld_base + hs_k);
                pend_data = in_data;
                hs_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("write_en", cache_write_en, pend_we);
            chk("addr_hi", cache_addr[29:12], 0);
            if (cache_write_en && pend_we) begin
                wr_seen++;
                chk("write_addr", cache_addr, {18'h0, pend_addr});
                chk("write_data", cache_wdata, pend_data);
            end
        end
    end

    task automatic do_load(input int base, input int count, input int vmode, input int corrupt,
                           input int lit_done, input bit poke, input bit rand_words);
        int cyc, done_cyc, last_hs, k, limit, exp_done, exp_err, exp_ea, exp_wr, nbad;
        bit bad;
        if (rand_words) for (int i = 0; i < count; i++) words[i] = $urandom;
        bad          = (base + count > 4096);
        ld_base      = base;
        hs_k         = 0;
        wr_seen      = 0;
        corrupt_on   = (corrupt >= 0);
        corrupt_addr = 12'(base + corrupt);
        start        = 1'b1;
        base_addr    = 12'(base);
        word_count   = 13'(count);
        in_valid     = 1'b1;
        in_data      = words[0];
        cyc = 0; k = 0; last_hs = -1; done_cyc = -1;
        limit = 4 * count + 60;
        while (cyc < limit) begin
            if (in_ready && in_valid) begin
                last_hs = cyc;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
            start      = poke && (cyc == 2);
            base_addr  = 12'($urandom);
            word_count = 13'($urandom_range(1, 4096));
            if (done) begin
                done_cyc = cyc;
                break;
            end
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = (k < count) ? words[k] : $urandom;
        end
        start    = 1'b0;
        in_valid = 1'b0;

        if (bad) begin
            exp_done = 1; exp_err = 1; exp_ea = base; exp_wr = model_written;
        end else if (count == 0) begin
            exp_done = 1; exp_err = 0; exp_ea = model_err_addr; exp_wr = 0;
        end else begin
            exp_wr   = count;
            exp_done = last_hs + 2;
            exp_err  = 0;
`ifdef INST_LOADER_VERIFY_EN
            exp_done += count + 1;
            exp_err   = (corrupt >= 0 && corrupt < count) ? 1 : 0;
`endif
            exp_ea = (exp_err != 0) ? (base + corrupt) % 4096 : model_err_addr;
        end

        if (done_cyc < 0) $display("FAIL done_timeout: no done within %0d cycles", limit);
        chk("done_cycle", done_cyc, exp_done);
        if (lit_done >= 0) chk("done_cycle_lit", done_cyc, lit_done);
        chk("error", error, exp_err);
        chk("err_addr", err_addr, exp_ea);
        chk("words_written", words_written, exp_wr);
        chk("busy_at_done", busy, 1);
        chk("write_pulses", wr_seen, bad ? 0 : count);
        nbad = 0;
        if (!bad) for (int i = 0; i < count; i++) if (mem[(base + i) % 4096] !== words[i]) nbad++;
        chk("mem_image", nbad, 0);
        @(posedge clk); #1;
        chk("done_pulse_end", done, 0);
        chk("busy_idle", busy, 0);
        model_written  = exp_wr;
        model_err_addr = exp_ea;
        corrupt_on     = 1'b0;
    endtask

    initial begin
        int k, nw, cnt, b, cr;
        bit got;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        base_addr = '0; word_count = '0;
        pend_we = 1'b0; corrupt_on = 1'b0; corrupt_addr = '0;
        ld_base = 0; hs_k = 0; wr_seen = 0; model_written = 0; model_err_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_write_en", cache_write_en, 0);
        chk("rst_addr", cache_addr, 0);
        chk("rst_wdata", cache_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_words", words_written, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        words[0] = 32'h2000_4693; words[1] = 32'h0000_1137; words[2] = 32'h0000_4533;
        do_load(0, 3, 0, -1, VER ? 9 : 5, 1'b0, 1'b0);
        do_load(100, 4, 1, -1, VER ? 15 : 10, 1'b0, 1'b1);
        do_load(4090, 7, 0, -1, 1, 1'b0, 1'b1);
        chk("range_err_addr_lit", err_addr, 4090);
`ifdef INST_LOADER_VERIFY_EN
        do_load(8, 4, 0, 2, 11, 1'b0, 1'b1);
        chk("corrupt_err_addr_lit", err_addr, 10);
`endif
        do_load(50, 0, 0, -1, 1, 1'b0, 1'b1);
        do_load(300, 5, 0, -1, VER ? 13 : 7, 1'b1, 1'b1);
        do_load(4093, 3, 0, -1, VER ? 9 : 5, 1'b0, 1'b1);
        do_load(4095, 2, 0, -1, 1, 1'b0, 1'b1);
        do_load(0, 4096, 0, -1, VER ? 8195 : 4098, 1'b0, 1'b1);
        do_load(1, 4096, 0, -1, 1, 1'b0, 1'b1);

        // Reset in the middle of the second write pulse.
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        ld_base = 200; hs_k = 0; wr_seen = 0;
        start = 1'b1; base_addr = 12'd200; word_count = 13'd5; in_valid = 1'b1; in_data = words[0];
        k = 0; nw = 0; got = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (in_ready && in_valid) k++;
            @(posedge clk); #1;
            start   = 1'b0;
            in_data = (k < 5) ? words[k] : 32'h0;
            if (cache_write_en) nw++;
            if (nw == 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_reached_2nd_write", got, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_write_en", cache_write_en, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_addr", cache_addr, 0);
        chk("midrst_wdata", cache_wdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        chk("midrst_err_addr", err_addr, 0);
        chk("midrst_words", words_written, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        model_written = 0; model_err_addr = 0;
        do_load(200, 3, 0, -1, VER ? 9 : 5, 1'b0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            cnt = $urandom_range(0, 24);
            b   = $urandom_range(0, 4095);
            if (t % 4 == 0) b = 4096 - cnt + $urandom_range(0, 2);
            if (b > 4095) b = 4095;
            cr = -1;
`ifdef INST_LOADER_VERIFY_EN
            if (t % 3 == 1 && cnt > 0) cr = $urandom_range(0, cnt - 1);
`endif
            do_load(b, cnt, 2, cr, -1, (t % 5 == 2), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
